// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: drives IMEM, queues {pc, inst} toward decode,
// handles redirects with flush and traps misaligned redirect targets.
//
// state    | meaning
// ST_BOOT  | one idle cycle after reset release, no fetch
// ST_RUN   | fetching and queueing, redirects accepted
// ST_FAULT | misaligned target trapped, waits for redirect or fault_clear
module inst_fetch_unit #(
  parameter int unsigned                 PC_WIDTH_LENGTH   = 32,
  parameter int unsigned                 INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0]  RESET_PC          = '0,
  parameter int unsigned                 BUF_DEPTH         = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  output logic [PC_WIDTH_LENGTH-1:0]    imem_pc_o,
  input  logic [INST_WIDTH_LENGTH-1:0]  imem_inst_i,
  input  logic                          redirect_valid_i,
  input  logic [PC_WIDTH_LENGTH-1:0]    redirect_pc_i,
  output logic                          out_valid_o,
  output logic [INST_WIDTH_LENGTH-1:0]  out_inst_o,
  output logic [PC_WIDTH_LENGTH-1:0]    out_pc_o,
  input  logic                          out_ready_i,
  output logic                          fault_o,
  output logic [PC_WIDTH_LENGTH-1:0]    fault_pc_o,
  input  logic                          fault_clear_i
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [PC_WIDTH_LENGTH-1:0] PC_STEP = PC_WIDTH_LENGTH'(4);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [PC_WIDTH_LENGTH-1:0]     fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic                           fault_q, fault_d;
  logic [PC_WIDTH_LENGTH-1:0]     fault_pc_q, fault_pc_d;
  logic [PC_WIDTH_LENGTH-1:0]     hold_pc_q;
  logic [INST_WIDTH_LENGTH-1:0]   hold_inst_q;
  logic [PC_WIDTH_LENGTH-1:0]     mem_pc_q   [BUF_DEPTH];
  logic [INST_WIDTH_LENGTH-1:0]   mem_inst_q [BUF_DEPTH];

  logic                           push, pop, out_valid;
  logic [PC_WIDTH_LENGTH-1:0]     head_pc;
  logic [INST_WIDTH_LENGTH-1:0]   head_inst;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count_q != '0);
  assign head_pc   = mem_pc_q[rd_ptr_q];
  assign head_inst = mem_inst_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        pop = out_valid & out_ready_i;
        if (redirect_valid_i) begin
          // Flush; a same-cycle pop is already consumed by decode.
          count_d  = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          if (redirect_pc_i[1:0] == 2'b00) begin
            fetch_pc_d = redirect_pc_i;
          end else begin
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc_i;
            state_d    = ST_FAULT;
          end
        end else begin
          push = (count_q < DEPTH_C) | pop;
          if (push) begin
            wr_ptr_d   = ptr_inc(wr_ptr_q);
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
          if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
          case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      end
      ST_FAULT: begin
        if (redirect_valid_i) begin
          if (redirect_pc_i[1:0] == 2'b00) begin
            fault_d    = 1'b0;
            fetch_pc_d = redirect_pc_i;
            state_d    = ST_RUN;
          end else begin
            fault_pc_d = redirect_pc_i;
          end
        end else if (fault_clear_i) begin
          fault_d    = 1'b0;
          fault_pc_d = '0;
          fetch_pc_d = RESET_PC;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_BOOT;
      fetch_pc_q  <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fault_q     <= 1'b0;
      fault_pc_q  <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      // Track the visible head so outputs keep their last value once empty.
      if (out_valid) begin
        hold_pc_q   <= head_pc;
        hold_inst_q <= head_inst;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else if (push) begin
      mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
      mem_inst_q[wr_ptr_q] <= imem_inst_i;
    end
  end

  assign imem_pc_o   = fetch_pc_q;
  assign out_valid_o = out_valid;
  assign out_pc_o    = out_valid ? head_pc : hold_pc_q;
  assign out_inst_o  = out_valid ? head_inst : hold_inst_q;
  assign fault_o     = fault_q;
  assign fault_pc_o  = fault_pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: vector table plus hand-written
// back-pressure, wrap-around and asynchronous reset sequences.
module tb_inst_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] imem_pc_o;
  logic [31:0] imem_inst_i;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        out_valid_o;
  logic [31:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        out_ready_i = 1'b0;
  logic        fault_o;
  logic [31:0] fault_pc_o;
  logic        fault_clear_i = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // IMEM model: word k holds 0x1000 + k.
  assign imem_inst_i = 32'h1000 + {2'b00, imem_pc_o[31:2]};

  inst_fetch_unit #(
    .PC_WIDTH_LENGTH   (32),
    .INST_WIDTH_LENGTH (32),
    .RESET_PC          (32'h0000_0000),
    .BUF_DEPTH         (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .imem_pc_o        (imem_pc_o),
    .imem_inst_i      (imem_inst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .out_valid_o      (out_valid_o),
    .out_inst_o       (out_inst_o),
    .out_pc_o         (out_pc_o),
    .out_ready_i      (out_ready_i),
    .fault_o          (fault_o),
    .fault_pc_o       (fault_pc_o),
    .fault_clear_i    (fault_clear_i)
  );

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        fc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        ef;
    logic [31:0] efpc;
    logic [31:0] eimem;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic ready, input logic rv, input logic [31:0] rpc,
                              input logic fc, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einst, input logic ef,
                              input logic [31:0] efpc, input logic [31:0] eimem);
    vec_t v;
    v.ready = ready; v.rv = rv; v.rpc = rpc; v.fc = fc;
    v.ev = ev; v.epc = epc; v.einst = einst; v.ef = ef; v.efpc = efpc; v.eimem = eimem;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released: cycle 0 (BOOT).
  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic drive(input logic ready, input logic rv, input logic [31:0] rpc, input logic fc);
    out_ready_i      = ready;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    fault_clear_i    = fc;
  endtask

  initial begin
    //            rdy rv  rpc           fc | ev  epc          einst         ef  efpc   eimem
    vecs[0]  = mk(1, 0, 32'h0,        0,  0, 32'h0,       32'h0,        0, 32'h0,  32'h0);
    vecs[1]  = mk(1, 0, 32'h0,        0,  0, 32'h0,       32'h0,        0, 32'h0,  32'h0);
    vecs[2]  = mk(1, 0, 32'h0,        0,  1, 32'h0,       32'h1000,     0, 32'h0,  32'h4);
    vecs[3]  = mk(1, 0, 32'h0,        0,  1, 32'h4,       32'h1001,     0, 32'h0,  32'h8);
    vecs[4]  = mk(0, 0, 32'h0,        0,  1, 32'h8,       32'h1002,     0, 32'h0,  32'hC);
    vecs[5]  = mk(0, 1, 32'h40,       0,  1, 32'h8,       32'h1002,     0, 32'h0,  32'h10);
    vecs[6]  = mk(1, 0, 32'h0,        0,  0, 32'h8,       32'h1002,     0, 32'h0,  32'h40);
    vecs[7]  = mk(1, 0, 32'h0,        0,  1, 32'h40,      32'h1010,     0, 32'h0,  32'h44);
    vecs[8]  = mk(1, 1, 32'h42,       0,  1, 32'h44,      32'h1011,     0, 32'h0,  32'h48);
    vecs[9]  = mk(1, 0, 32'h0,        0,  0, 32'h44,      32'h1011,     1, 32'h42, 32'h48);
    vecs[10] = mk(1, 1, 32'h81,       0,  0, 32'h44,      32'h1011,     1, 32'h42, 32'h48);
    vecs[11] = mk(1, 1, 32'h80,       0,  0, 32'h44,      32'h1011,     1, 32'h81, 32'h48);
    vecs[12] = mk(1, 0, 32'h0,        0,  0, 32'h44,      32'h1011,     0, 32'h81, 32'h80);
    vecs[13] = mk(1, 0, 32'h0,        1,  1, 32'h80,      32'h1020,     0, 32'h81, 32'h84);
    vecs[14] = mk(1, 1, 32'h3,        0,  1, 32'h84,      32'h1021,     0, 32'h81, 32'h88);
    vecs[15] = mk(1, 1, 32'h7,        1,  0, 32'h84,      32'h1021,     1, 32'h3,  32'h88);
    vecs[16] = mk(1, 0, 32'h0,        1,  0, 32'h84,      32'h1021,     1, 32'h7,  32'h88);
    vecs[17] = mk(1, 0, 32'h0,        0,  0, 32'h84,      32'h1021,     0, 32'h0,  32'h0);
    vecs[18] = mk(1, 0, 32'h0,        0,  1, 32'h0,       32'h1000,     0, 32'h0,  32'h4);
    vecs[19] = mk(1, 0, 32'h0,        0,  1, 32'h4,       32'h1001,     0, 32'h0,  32'h8);

    // Values while held in reset.
    #3;
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_imem_pc", imem_pc_o, 32'h0);
    chk("rst_out_pc", out_pc_o, 32'h0);
    chk("rst_out_inst", out_inst_o, 32'h0);
    chk("rst_fault", {31'd0, fault_o}, 32'd0);
    chk("rst_fault_pc", fault_pc_o, 32'h0);

    // Streaming, redirect, misaligned trap, fault recovery and fault_clear.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ready, vecs[i].rv, vecs[i].rpc, vecs[i].fc);
      @(negedge clk_i);
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid_o}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d_out_pc", i), out_pc_o, vecs[i].epc);
      chk($sformatf("v%0d_out_inst", i), out_inst_o, vecs[i].einst);
      chk($sformatf("v%0d_fault", i), {31'd0, fault_o}, {31'd0, vecs[i].ef});
      chk($sformatf("v%0d_fault_pc", i), fault_pc_o, vecs[i].efpc);
      chk($sformatf("v%0d_imem_pc", i), imem_pc_o, vecs[i].eimem);
      adv();
    end

    // Back-pressure from reset: FIFO fills with pc 0 and 4, fetch holds at 8.
    drive(0, 0, 32'h0, 0);
    do_reset();
    repeat (3) adv();
    @(negedge clk_i);
    chk("bp_full_valid", {31'd0, out_valid_o}, 32'd1);
    chk("bp_full_pc", out_pc_o, 32'h0);
    chk("bp_full_imem", imem_pc_o, 32'h8);
    adv();
    @(negedge clk_i);
    chk("bp_hold_imem", imem_pc_o, 32'h8);
    chk("bp_hold_pc", out_pc_o, 32'h0);
    adv();
    drive(1, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk($sformatf("bp_rel%0d_valid", k), {31'd0, out_valid_o}, 32'd1);
      chk($sformatf("bp_rel%0d_pc", k), out_pc_o, 32'(4 * k));
      chk($sformatf("bp_rel%0d_inst", k), out_inst_o, 32'h1000 + 32'(k));
      adv();
    end

    // Redirect to the top word; the fetch address wraps to zero.
    drive(1, 1, 32'hFFFF_FFFC, 0);
    adv();
    drive(1, 0, 32'h0, 0);
    @(negedge clk_i);
    chk("wrap_flush_valid", {31'd0, out_valid_o}, 32'd0);
    chk("wrap_flush_imem", imem_pc_o, 32'hFFFF_FFFC);
    adv();
    @(negedge clk_i);
    chk("wrap_top_valid", {31'd0, out_valid_o}, 32'd1);
    chk("wrap_top_pc", out_pc_o, 32'hFFFF_FFFC);
    chk("wrap_top_inst", out_inst_o, 32'h4000_0FFF);
    chk("wrap_top_imem", imem_pc_o, 32'h0);
    adv();
    @(negedge clk_i);
    chk("wrap_zero_pc", out_pc_o, 32'h0);
    chk("wrap_zero_inst", out_inst_o, 32'h1000);
    chk("wrap_zero_imem", imem_pc_o, 32'h4);

    // Asynchronous reset off a clock edge while the FIFO is non-empty.
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("arst_imem", imem_pc_o, 32'h0);
    chk("arst_out_pc", out_pc_o, 32'h0);
    chk("arst_out_inst", out_inst_o, 32'h0);
    @(posedge clk_i);
    #1;
    chk("arst_held_valid", {31'd0, out_valid_o}, 32'd0);
    chk("arst_held_imem", imem_pc_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch-side initiator for the instruction memory. Drives the word-aligned fetch address, captures the returned instruction word, and queues {pc, inst} pairs in a small FIFO toward decode.
- Handles decode back-pressure, branch/jump redirects with buffer flush, and misaligned-target faults.
- Sits between the IMEM read port (combinational, same-cycle data) and the decode stage.

Parameters:
- PC_WIDTH_LENGTH, 32, width of all PC/address signals.
- INST_WIDTH_LENGTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset or fault_clear.
- BUF_DEPTH, 2, FIFO entries; any value ≥ 2 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_pc  output  PC_WIDTH_LENGTH  fetch address to IMEM; always word aligned.
- imem_inst  input  INST_WIDTH_LENGTH  IMEM read data for imem_pc, valid the same cycle.
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  PC_WIDTH_LENGTH  redirect target.
- out_valid  output  1  FIFO head valid toward decode.
- out_inst  output  INST_WIDTH_LENGTH  FIFO head instruction.
- out_pc  output  PC_WIDTH_LENGTH  FIFO head PC.
- out_ready  input  1  decode accepts the head this cycle.
- fault  output  1  misaligned redirect trapped.
- fault_pc  output  PC_WIDTH_LENGTH  offending redirect target.
- fault_clear  input  1  leave FAULT and restart at RESET_PC.

Behaviour:
- Reset (rst_n low, async):
  - imem_pc = fetch_pc = RESET_PC.
  - FIFO count = 0, so out_valid = 0.
  - out_inst = 0, out_pc = 0, fault = 0, fault_pc = 0.
  - State = BOOT.
  - Reset asserted mid-operation discards everything immediately.
- imem_pc is combinationally equal to the fetch_pc register.
- States:
  - BOOT: lasts exactly one cycle after reset release. No fetch. Next state is RUN.
  - RUN:
    - pop = out_valid & out_ready.
    - push = (count < BUF_DEPTH) | pop.
    - On push: write {fetch_pc, imem_inst} at the FIFO tail and set fetch_pc <= fetch_pc + 4. The add wraps modulo 2^PC_WIDTH_LENGTH (0xFFFF_FFFC -> 0x0000_0000).
    - Simultaneous push and pop with the FIFO full is legal; count is unchanged.
    - When count = BUF_DEPTH and no pop: hold fetch_pc, no push.
  - Redirect in RUN (highest priority):
    - Flush the FIFO (count <= 0). No push that cycle.
    - A pop in the same cycle still counts as consumed by decode.
    - If redirect_pc[1:0] == 0: fetch_pc <= redirect_pc; stay in RUN.
    - Otherwise: fault <= 1, fault_pc <= redirect_pc, fetch_pc unchanged, next state FAULT.
  - FAULT:
    - No fetch; FIFO empty; out_valid = 0; fault held at 1.
    - An aligned redirect: fault <= 0, fetch_pc <= redirect_pc, next state RUN.
    - A misaligned redirect: updates fault_pc and stays in FAULT.
    - fault_clear (with no redirect): fault <= 0, fault_pc <= 0, fetch_pc <= RESET_PC, next state RUN.
    - Redirect has priority over fault_clear.
  - fault_clear is ignored outside FAULT.
- FIFO:
  - out_valid = (count != 0); out_inst/out_pc show the head entry.
  - out_inst/out_pc hold their last values while empty.
  - Entries leave strictly in fetch order.
- Latency:
  - Fetch at cycle N -> visible on out_* at cycle N+1 when the FIFO was empty.
  - First instruction after reset release: BOOT at cycle 0, fetch at cycle 1, out_valid = 1 with out_pc = RESET_PC at cycle 2.
  - After a redirect at cycle N: first target fetch at N+1, visible at N+2.
- imem_pc[1:0] is never non-zero, so IMEM never returns high-Z data into the FIFO.

Test Plan:
- Streaming: release reset, out_ready = 1, IMEM holds word k = 0x1000+k.
  - Expect out_valid rising at cycle 2.
  - Expect out_pc sequence 0, 4, 8, ... with out_inst 0x1000, 0x1001, ..., one per cycle.
- Back-pressure: out_ready = 0 for 5 cycles, then 1.
  - FIFO fills to 2 entries (pc 0, 4) and imem_pc holds at 8.
  - On release, delivery resumes 0, 4, 8 with no loss or duplicate.
- Redirect: redirect_valid with redirect_pc = 0x40 while the FIFO holds pc 8 and 0xC.
  - Next cycle out_valid = 0.
  - The following cycle out_pc = 0x40; 8 and 0xC are never delivered.
- Misaligned redirect: redirect_pc = 0x42.
  - Expect fault = 1, fault_pc = 0x42, out_valid = 0, imem_pc frozen.
  - A subsequent redirect to 0x80 resumes with out_pc = 0x80 two cycles later and fault = 0.
- fault_clear: from FAULT, pulse fault_clear.
  - Expect fault = 0, fault_pc = 0, and out_pc = RESET_PC two cycles later.
- Wrap and async reset:
  - Redirect to 0xFFFF_FFFC; expect out_pc 0xFFFF_FFFC then 0x0000_0000.
  - Assert rst_n low mid-stream, off a clock edge; expect out_valid = 0 and imem_pc = 0 immediately.
